// File: rtl/snake_pkg.sv
// Shared snake game definitions: board geometry, cell-index field layout and
// the food spawner state encoding.
package snake_pkg;

  localparam int BOARD_CELLS = 64;
  localparam int POS_W       = 6;

  // Cell index layout {row, col}, shared with the logic datapath and display mux
  localparam int ROW_MSB = 5;
  localparam int ROW_LSB = 3;
  localparam int COL_MSB = 2;
  localparam int COL_LSB = 0;

  typedef enum logic [2:0] {
    SP_IDLE     = 3'd0,
    SP_REQ_RAND = 3'd1,
    SP_CHECK    = 3'd2,
    SP_SCAN     = 3'd3,
    SP_DONE     = 3'd4
  } spawn_state_e;

endpackage

// File: rtl/food_spawner.sv
// Food placement scheduler: draws PRNG candidates against the occupancy map,
// then falls back to a wrap-around linear scan; reports a free cell or board full.
module food_spawner
  import snake_pkg::*;
#(
  parameter int MAX_TRIES = 8
) (
  input  logic                   clka,
  input  logic                   restart_n,
  input  logic                   spawn_req,
  input  logic [BOARD_CELLS-1:0] occupancy_flat,
  output logic                   rand_req,
  input  logic                   rand_ack,
  input  logic [POS_W-1:0]       rand_val,
  output logic [POS_W-1:0]       food_pos,
  output logic                   food_valid,
  output logic                   board_full,
  output logic                   spawn_done,
  output logic                   busy
);

  localparam logic [3:0] MAX_TRIES_W = MAX_TRIES[3:0];
  localparam logic [5:0] SCAN_LAST   = 6'd62;

  spawn_state_e     state_q, state_d;
  logic [POS_W-1:0] cand_q, cand_d;
  logic [POS_W-1:0] idx_q, idx_d;
  logic [5:0]       scanned_q, scanned_d;
  logic [3:0]       tries_q, tries_d;
  logic [POS_W-1:0] food_pos_q, food_pos_d;
  logic             rand_req_q, rand_req_d;
  logic             food_valid_q, food_valid_d;
  logic             board_full_q, board_full_d;
  logic             spawn_done_q, spawn_done_d;
  logic             busy_q, busy_d;

  logic [POS_W-1:0] lookup_idx;
  logic             cell_occupied;
  logic [3:0]       tries_inc;

  // One 64:1 lookup shared by CHECK (candidate) and SCAN (linear index)
  assign lookup_idx    = (state_q == SP_SCAN) ? idx_q : cand_q;
  assign cell_occupied = occupancy_flat[lookup_idx];
  assign tries_inc     = tries_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    idx_d        = idx_q;
    scanned_d    = scanned_q;
    tries_d      = tries_q;
    food_pos_d   = food_pos_q;
    rand_req_d   = rand_req_q;
    food_valid_d = food_valid_q;
    board_full_d = board_full_q;
    spawn_done_d = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      SP_IDLE: begin
        if (spawn_req) begin
          food_valid_d = 1'b0;
          board_full_d = 1'b0;
          tries_d      = 4'd0;
          busy_d       = 1'b1;
          rand_req_d   = 1'b1;
          state_d      = SP_REQ_RAND;
        end
      end
      SP_REQ_RAND: begin
        if (rand_ack) begin
          cand_d     = rand_val;
          rand_req_d = 1'b0;
          state_d    = SP_CHECK;
        end
      end
      SP_CHECK: begin
        if (!cell_occupied) begin
          food_pos_d   = cand_q;
          food_valid_d = 1'b1;
          spawn_done_d = 1'b1;
          state_d      = SP_DONE;
        end else begin
          tries_d = tries_inc;
          if (tries_inc == MAX_TRIES_W) begin
            idx_d     = cand_q + 6'd1;
            scanned_d = 6'd0;
            state_d   = SP_SCAN;
          end else begin
            rand_req_d = 1'b1;
            state_d    = SP_REQ_RAND;
          end
        end
      end
      SP_SCAN: begin
        if (!cell_occupied) begin
          food_pos_d   = idx_q;
          food_valid_d = 1'b1;
          spawn_done_d = 1'b1;
          state_d      = SP_DONE;
        end else if (scanned_q == SCAN_LAST) begin
          board_full_d = 1'b1;
          spawn_done_d = 1'b1;
          state_d      = SP_DONE;
        end else begin
          idx_d     = idx_q + 6'd1;
          scanned_d = scanned_q + 6'd1;
        end
      end
      SP_DONE: begin
        busy_d  = 1'b0;
        state_d = SP_IDLE;
      end
      default: begin
        state_d    = SP_IDLE;
        rand_req_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q      <= SP_IDLE;
      cand_q       <= '0;
      idx_q        <= '0;
      scanned_q    <= '0;
      tries_q      <= '0;
      food_pos_q   <= '0;
      rand_req_q   <= 1'b0;
      food_valid_q <= 1'b0;
      board_full_q <= 1'b0;
      spawn_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      idx_q        <= idx_d;
      scanned_q    <= scanned_d;
      tries_q      <= tries_d;
      food_pos_q   <= food_pos_d;
      rand_req_q   <= rand_req_d;
      food_valid_q <= food_valid_d;
      board_full_q <= board_full_d;
      spawn_done_q <= spawn_done_d;
      busy_q       <= busy_d;
    end
  end

  assign rand_req   = rand_req_q;
  assign food_pos   = food_pos_q;
  assign food_valid = food_valid_q;
  assign board_full = board_full_q;
  assign spawn_done = spawn_done_q;
  assign busy       = busy_q;

endmodule
